// File: rtl/spi_peripheral_device_pkg.sv
// Shared constants and state encodings for the SPI peripheral device and its
// response serializer.
package spi_peripheral_device_pkg;

    localparam int unsigned CmdWidth = 32;
    localparam int unsigned RspWidth = 8;
    localparam int unsigned RegCount = 16;

    localparam logic [7:0] OpWrite = 8'hA1;
    localparam logic [7:0] OpRead  = 8'hA2;
    localparam logic [7:0] OpEcho  = 8'hA3;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_GAP
    } tx_state_e;

    // Opcodes that produce a frame on MISO.
    function automatic logic is_response(input logic [7:0] op);
        return (op == OpRead) || (op == OpEcho);
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Response serializer: start bit (0), 8 data bits MSB first, then GAP_CYCLES
// idle-high cycles before another frame may start.
module spi_frame_tx
    import spi_peripheral_device_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RspWidth-1:0] data,
    output logic                busy,
    output logic                miso
);

    localparam int unsigned CntMax = (GAP_CYCLES > RspWidth) ? GAP_CYCLES : RspWidth;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    tx_state_e           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RspWidth-1:0] shreg_q, shreg_d;
    logic                miso_q, miso_d;

    // miso_d is derived from the upcoming state so the pin itself is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        miso_d  = 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    shreg_d = data;
                    miso_d  = 1'b0;
                end
            end
            TX_START: begin
                state_d = TX_DATA;
                cnt_d   = '0;
                miso_d  = shreg_q[RspWidth-1];
                shreg_d = {shreg_q[RspWidth-2:0], 1'b1};
            end
            TX_DATA: begin
                if (cnt_q == CntW'(RspWidth - 1)) begin
                    state_d = TX_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    miso_d  = shreg_q[RspWidth-1];
                    shreg_d = {shreg_q[RspWidth-2:0], 1'b1};
                end
            end
            TX_GAP: begin
                if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            miso_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            miso_q  <= miso_d;
        end
    end

    assign busy = (state_q != TX_IDLE);
    assign miso = miso_q;

endmodule

// File: rtl/spi_peripheral_device.sv
// SPI peripheral: receives 32-bit command frames on MOSI, maintains a 16x8
// register file and returns READ/ECHO responses on MISO.
module spi_peripheral_device
    import spi_peripheral_device_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spi_cs,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic [CmdWidth-1:0] rx_word,
    output logic                rx_valid,
    output logic                frame_err,
    output logic                cmd_err
);

    rx_state_e           rx_state_q, rx_state_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [CmdWidth-1:0] shreg_q, shreg_d;
    logic [CmdWidth-1:0] rx_word_q, rx_word_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                cmd_err_q, cmd_err_d;

    logic [RspWidth-1:0] reg_file_q [RegCount];

    logic [7:0]          opcode;
    logic [3:0]          index;
    logic                wr_en;
    logic                tx_start;
    logic                tx_busy;
    logic [RspWidth-1:0] tx_data;

    always_comb begin
        rx_state_d  = rx_state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_word_d   = rx_word_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (spi_cs && !spi_mosi) begin
                    rx_state_d = RX_SHIFT;
                    bit_cnt_d  = '0;
                end
            end
            RX_SHIFT: begin
                if (!spi_cs) begin
                    rx_state_d  = RX_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    shreg_d = {shreg_q[CmdWidth-2:0], spi_mosi};
                    if (bit_cnt_q == 5'(CmdWidth - 1)) begin
                        rx_state_d = RX_IDLE;
                        rx_word_d  = {shreg_q[CmdWidth-2:0], spi_mosi};
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_word_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_word_q   <= rx_word_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Decode runs in the cycle rx_valid is high, directly off the stored word.
    assign opcode  = rx_word_q[31:24];
    assign index   = rx_word_q[19:16];
    assign tx_data = (opcode == OpRead) ? reg_file_q[index] : rx_word_q[RspWidth-1:0];

    always_comb begin
        wr_en     = 1'b0;
        tx_start  = 1'b0;
        cmd_err_d = 1'b0;
        if (rx_valid_q) begin
            if (opcode == OpWrite) begin
                wr_en = 1'b1;
            end else if (is_response(opcode)) begin
                // A response cannot preempt one already on the wire.
                if (tx_busy) begin
                    cmd_err_d = 1'b1;
                end else begin
                    tx_start = 1'b1;
                end
            end else begin
                cmd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err_q <= 1'b0;
            for (int i = 0; i < RegCount; i++) begin
                reg_file_q[i] <= '0;
            end
        end else begin
            cmd_err_q <= cmd_err_d;
            if (wr_en) begin
                reg_file_q[index] <= rx_word_q[RspWidth-1:0];
            end
        end
    end

    spi_frame_tx #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_frame_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (tx_data),
        .busy (tx_busy),
        .miso (spi_miso)
    );

    assign rx_word   = rx_word_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_peripheral_device.sv
// Self-checking bench for spi_peripheral_device: scoreboard queues for
// received words and response frames, checked by a negedge monitor.
module tb_spi_peripheral_device;

    // Long enough gap that a response is still busy when a back-to-back
    // frame (33-cycle spacing) decodes.
    localparam int unsigned GAP = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic [31:0] rx_word;
    logic        rx_valid;
    logic        frame_err;
    logic        cmd_err;

    spi_peripheral_device #(
        .GAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_cs   (spi_cs),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .rx_word  (rx_word),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } tx_exp_t;

    typedef struct {
        logic [31:0] word;
        int          at;
    } rx_exp_t;

    tx_exp_t     txq[$];
    rx_exp_t     rxq[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_rxv = 0;
    int          n_fe = 0;
    int          n_ce = 0;
    int          n_frames = 0;
    int          busy_until = 0;
    logic [7:0]  model_rf [16];
    logic [31:0] last_word = '0;

    // Monitor: rx_word scoreboard, pulse counters, MISO frame decoder.
    initial begin
        int         mon_st;
        int         mon_n;
        logic [7:0] mon_byte;
        tx_exp_t    te;
        rx_exp_t    re;
        mon_st = 0;
        mon_n = 0;
        mon_byte = '0;
        te.data = '0;
        te.start = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_st = 0;
                txq.delete();
            end else begin
                if (rx_valid === 1'b1) begin
                    n_rxv++;
                    n_cmp++;
                    if (rxq.size() == 0) begin
                        n_fail++;
                        $display("FAIL rx_valid_unexpected: got rx_word=%h at cycle %0d, required no pulse",
                                 rx_word, cyc);
                    end else begin
                        re = rxq.pop_front();
                        if (rx_word !== re.word || cyc != re.at) begin
                            n_fail++;
                            $display("FAIL rx_word: got %h at cycle %0d, required %h at cycle %0d",
                                     rx_word, cyc, re.word, re.at);
                        end
                    end
                end
                if (frame_err === 1'b1) n_fe++;
                if (cmd_err === 1'b1) n_ce++;
                case (mon_st)
                    0: begin
                        if (spi_miso !== 1'b1) begin
                            n_frames++;
                            n_cmp++;
                            if (txq.size() == 0) begin
                                n_fail++;
                                $display("FAIL miso_unexpected_frame: got miso=%b at cycle %0d, required 1",
                                         spi_miso, cyc);
                                te.data = 'x;
                            end else begin
                                te = txq.pop_front();
                                if (cyc != te.start) begin
                                    n_fail++;
                                    $display("FAIL miso_start_cycle: got cycle %0d, required %0d",
                                             cyc, te.start);
                                end
                            end
                            mon_byte = '0;
                            mon_n = 0;
                            mon_st = 1;
                        end
                    end
                    1: begin
                        mon_byte = {mon_byte[6:0], spi_miso};
                        mon_n++;
                        if (mon_n == 8) begin
                            n_cmp++;
                            if (mon_byte !== te.data) begin
                                n_fail++;
                                $display("FAIL miso_data: got %h, required %h", mon_byte, te.data);
                            end
                            mon_n = 0;
                            mon_st = 2;
                        end
                    end
                    default: begin
                        if (spi_miso !== 1'b1) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL miso_gap: got miso=%b after %0d gap cycles, required %0d ones",
                                     spi_miso, mon_n, GAP);
                            mon_st = 0;
                        end else begin
                            mon_n++;
                            if (mon_n == int'(GAP)) begin
                                n_cmp++;
                                mon_st = 0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        spi_cs = 1'b0;
        spi_mosi = 1'b1;
        repeat (n) tick();
    endtask

    // Start bit plus 32 payload bits; the model predicts the DUT reaction.
    task automatic send_frame(input logic [31:0] w, input bit keep_cs);
        int         c_last;
        int         d;
        logic [7:0] op;
        logic [3:0] idx;
        rx_exp_t    re;
        tx_exp_t    te;
        tick();
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        c_last = cyc;
        for (int i = 31; i >= 0; i--) begin
            tick();
            spi_mosi = w[i];
            c_last = cyc;
        end
        d = c_last + 1;
        re.word = w;
        re.at = d;
        rxq.push_back(re);
        last_word = w;
        op = w[31:24];
        idx = w[19:16];
        if (op == 8'hA1) begin
            model_rf[idx] = w[7:0];
        end else if (op == 8'hA2 || op == 8'hA3) begin
            if (d >= busy_until) begin
                te.data = (op == 8'hA2) ? model_rf[idx] : w[7:0];
                te.start = d + 1;
                txq.push_back(te);
                busy_until = d + 1 + 9 + int'(GAP);
            end
        end
        if (!keep_cs) begin
            tick();
            spi_cs = 1'b0;
            spi_mosi = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi_cs = 1'b0;
        spi_mosi = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) model_rf[i] = '0;
        n_cmp++;
        if (spi_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_miso: got %b, required 1", spi_miso);
        end
        n_cmp++;
        if (rx_word !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rx_word: got %h, required 00000000", rx_word);
        end
        n_cmp++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0 || cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got rx_valid=%b frame_err=%b cmd_err=%b, required 0 0 0",
                     rx_valid, frame_err, cmd_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int rv0 = n_rxv;
        int fr0 = n_frames;
        int ce0 = n_ce;
        send_frame(32'hA1050055, 1'b0);
        idle(2);
        send_frame(32'hA2050000, 1'b0);
        idle(GAP + 15);
        n_cmp++;
        if (n_rxv - rv0 != 2) begin
            n_fail++;
            $display("FAIL write_read_rx_valid: got %0d pulses, required 2", n_rxv - rv0);
        end
        n_cmp++;
        if (n_frames - fr0 != 1 || n_ce - ce0 != 0) begin
            n_fail++;
            $display("FAIL write_read_frames: got %0d frames %0d cmd_err, required 1 frame 0 cmd_err",
                     n_frames - fr0, n_ce - ce0);
        end
    endtask

    task automatic test_echo();
        int fr0 = n_frames;
        send_frame(32'hA30000C3, 1'b0);
        idle(GAP + 15);
        n_cmp++;
        if (rx_word !== 32'hA30000C3) begin
            n_fail++;
            $display("FAIL echo_rx_word: got %h, required a30000c3", rx_word);
        end
        n_cmp++;
        if (n_frames - fr0 != 1) begin
            n_fail++;
            $display("FAIL echo_frames: got %0d, required 1", n_frames - fr0);
        end
    endtask

    task automatic test_frame_abort();
        int rv0 = n_rxv;
        int fe0 = n_fe;
        int fr0 = n_frames;
        logic [31:0] w = 32'hA3FF00FF;
        tick();
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        for (int i = 31; i >= 22; i--) begin
            tick();
            spi_mosi = w[i];
        end
        idle(30);
        n_cmp++;
        if (n_fe - fe0 != 1) begin
            n_fail++;
            $display("FAIL abort_frame_err: got %0d pulses, required 1", n_fe - fe0);
        end
        n_cmp++;
        if (n_rxv - rv0 != 0) begin
            n_fail++;
            $display("FAIL abort_rx_valid: got %0d pulses, required 0", n_rxv - rv0);
        end
        n_cmp++;
        if (rx_word !== last_word) begin
            n_fail++;
            $display("FAIL abort_rx_word: got %h, required %h", rx_word, last_word);
        end
        n_cmp++;
        if (n_frames - fr0 != 0 || spi_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_miso: got %0d frames miso=%b, required 0 frames miso=1",
                     n_frames - fr0, spi_miso);
        end
    endtask

    task automatic test_back_to_back();
        int fr0 = n_frames;
        int ce0 = n_ce;
        send_frame(32'hA30000AA, 1'b1);
        send_frame(32'hA3000011, 1'b0);
        idle(GAP + 20);
        n_cmp++;
        if (n_frames - fr0 != 1) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d, required 1", n_frames - fr0);
        end
        n_cmp++;
        if (n_ce - ce0 != 1) begin
            n_fail++;
            $display("FAIL b2b_cmd_err: got %0d pulses, required 1", n_ce - ce0);
        end
    endtask

    task automatic test_unknown_opcode();
        int fr0 = n_frames;
        int ce0 = n_ce;
        send_frame(32'h00000000, 1'b0);
        idle(30);
        n_cmp++;
        if (n_ce - ce0 != 1) begin
            n_fail++;
            $display("FAIL unknown_cmd_err: got %0d pulses, required 1", n_ce - ce0);
        end
        n_cmp++;
        if (n_frames - fr0 != 0) begin
            n_fail++;
            $display("FAIL unknown_miso: got %0d frames, required 0", n_frames - fr0);
        end
        // reg_file[5] must still hold 0x55.
        send_frame(32'hA2050000, 1'b0);
        idle(GAP + 15);
    endtask

    task automatic test_reset_mid_tx();
        int fr0;
        send_frame(32'hA2050000, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_rf[i] = '0;
        busy_until = 0;
        last_word = '0;
        txq.delete();
        n_cmp++;
        if (spi_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_tx_miso: got %b, required 1", spi_miso);
        end
        idle(5);
        fr0 = n_frames;
        send_frame(32'hA2050000, 1'b0);
        idle(GAP + 15);
        n_cmp++;
        if (n_frames - fr0 != 1) begin
            n_fail++;
            $display("FAIL rst_mid_tx_read: got %0d frames, required 1", n_frames - fr0);
        end
    endtask

    initial begin
        rst = 1'b1;
        spi_cs = 1'b0;
        spi_mosi = 1'b1;
        test_reset();
        test_write_read();
        test_echo();
        test_frame_abort();
        test_back_to_back();
        test_unknown_opcode();
        test_reset_mid_tx();
        n_cmp++;
        if (txq.size() != 0 || rxq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d tx %0d rx pending, required 0 0",
                     txq.size(), rxq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_peripheral_device.md
SPI_PERIPHERAL_DEVICE -- requirements
Module: spi_peripheral_device

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16: minimum idle-high MISO cycles after each response frame.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; the controller's spi_sclk is this same clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port spi_cs, input, 1 bit: frame enable, high during start bit and payload.
REQ-005 SHALL have port spi_mosi, input, 1 bit: serial command from the controller.
REQ-006 SHALL have port spi_miso, output, 1 bit: serial response to the controller; registered.
REQ-007 SHALL have port rx_word, output, 32 bits: last complete command word.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_word updates.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on an aborted receive frame.
REQ-010 SHALL have port cmd_err, output, 1 bit: one-cycle pulse on an unknown opcode or a response overrun.

Function
REQ-011 RX FSM SHALL have states RX_IDLE and RX_SHIFT, plus a 5-bit bit counter.
REQ-012 RX_IDLE SHALL go to RX_SHIFT with the counter cleared when spi_cs=1 and spi_mosi=0 (start bit).
REQ-013 RX_SHIFT SHALL sample spi_mosi on every clk while spi_cs=1, shifting MSB first (the first payload bit is bit 31).
REQ-014 After the 32nd bit is sampled in cycle N, rx_word SHALL update and rx_valid SHALL pulse in cycle N+1, and the FSM SHALL return to RX_IDLE.
REQ-015 If spi_cs=0 in RX_SHIFT before 32 bits, the frame SHALL be discarded, frame_err SHALL pulse for one cycle, the FSM SHALL go to RX_IDLE, and rx_word SHALL be unchanged.
REQ-016 Command decode SHALL occur on rx_valid, with opcode = rx_word[31:24] and index = rx_word[19:16].
REQ-017 Opcode 8'hA1 (WRITE) SHALL write rx_word[7:0] into reg_file[index] (16 x 8 bits) and send no response.
REQ-018 Opcode 8'hA2 (READ) SHALL send a response frame carrying reg_file[index].
REQ-019 Opcode 8'hA3 (ECHO) SHALL send a response frame carrying rx_word[7:0].
REQ-020 Any other opcode SHALL be ignored and SHALL pulse cmd_err.
REQ-021 TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA (8 cycles), and TX_GAP (GAP_CYCLES cycles).
REQ-022 spi_miso SHALL be 1 in TX_IDLE and TX_GAP, 0 in TX_START, and data bits 7..0 in successive TX_DATA cycles.
REQ-023 When a response is decoded from rx_valid in cycle N+1, spi_miso SHALL be 0 (start bit) in cycle N+2 and carry bit7 in cycle N+3.
REQ-024 A READ or ECHO arriving while the TX FSM is not in TX_IDLE SHALL be dropped and SHALL pulse cmd_err; the frame in flight SHALL be unaffected.
REQ-025 A WRITE SHALL take effect regardless of TX state.
REQ-026 A READ of an index SHALL return data written by any earlier completed WRITE to that index.
REQ-027 RX and TX SHALL operate concurrently, so a new command may be received while a response is shifting out.

Reset
REQ-028 When rst=1, at the next clk both FSMs SHALL go to idle, spi_miso=1, rx_word=0, rx_valid=0, frame_err=0, cmd_err=0, and every reg_file entry=0.
REQ-029 rst asserted mid-frame SHALL abandon RX and TX immediately, with no error pulse and no reg_file write.

Structure
REQ-030 A shared package SHALL hold the opcode constants (8'hA1, 8'hA2, 8'hA3), the RX and TX state encodings, and the frame widths (32 bits command, 8 bits response).
REQ-031 The TX serializer SHALL be a sub-module named spi_frame_tx with inputs start and data[7:0], outputs busy and miso, and parameter GAP_CYCLES.

Verification
REQ-032 Send 32'hA1050055, then 32'hA2050000: rx_valid SHALL pulse twice; spi_miso SHALL show 0 followed by 0,1,0,1,0,1,0,1 (0x55), then at least 16 ones.
REQ-033 Send 32'hA30000C3: rx_word=32'hA30000C3; the start bit SHALL appear 2 cycles after the last MOSI bit, followed by the bits of 0xC3.
REQ-034 Drop spi_cs after 10 payload bits: frame_err SHALL pulse once, rx_valid SHALL stay 0, rx_word SHALL be unchanged, and spi_miso SHALL stay 1.
REQ-035 Send two ECHO frames back-to-back (33-cycle spacing): the first response SHALL be sent intact, and the second SHALL pulse cmd_err with no second frame on spi_miso.
REQ-036 Send 32'h00000000: cmd_err SHALL pulse, and spi_miso and reg_file SHALL be unchanged.
REQ-037 Assert rst during TX_DATA: spi_miso=1 from the next cycle, and a subsequent READ of index 5 SHALL return 0x00.
